ofm_writer: RTL
===============

# ofm_writer

Output-side write-back controller for the convolution engine. It consumes the stream of MAC products produced for the input-feature-map and weight reads, and accumulates K·K·IN_CH products per output pixel. It then scales, saturates and optionally rectifies each result and writes it to the output feature-map buffer at the matching (m, r, c) location. Loop order matches the read side: m outer, then r, then c, with the n/i/j reduction innermost.

## Interface
- K, 5 — kernel size.
- IN_CH, 1 — input channels in the reduction.
- OUT_SIZE, 28 — output rows and columns.
- OUT_CH, 6 — output channels, at most 8.
- FRAC, 8 — arithmetic right shift applied to the accumulator before saturation.
- RELU, 1 — when 1, clamp negative results to 0.
- clock  in  1  — single clock; all logic is on the rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- start  in  1  — one-cycle pulse that begins a layer; honoured only in IDLE.
- prod_valid  in  1  — prod_data is valid this cycle.
- prod_data  in  16  — signed MAC product.
- prod_ready  out  1  — high in RUN only; a product transfers when prod_valid && prod_ready.
- out_ena  out  1  — output buffer enable; pulses together with the write.
- out_wea  out  8  — one-hot lane write enable, bit m selects output channel m.
- out_addr  out  16  — r·OUT_SIZE + c.
- out_din  out  16  — signed result.
- busy  out  1  — high in RUN.
- done  out  1  — one-cycle pulse after the final write.

## Operation
- States:
  - IDLE: on start, go to RUN and clear all counters and the accumulator.
  - RUN: on the final accepted product of the last pixel of the last channel, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Counters:
  - acc_cnt runs 0..K·K·IN_CH−1.
  - c runs 0..OUT_SIZE−1, r runs 0..OUT_SIZE−1, m runs 0..OUT_CH−1.
  - Each counter advances on the wrap of the one below it; acc_cnt advances on every accepted product.
- Accumulator: 32-bit signed. prod_data is sign-extended and added on each accepted product.
- On an accepted product with acc_cnt = K·K·IN_CH−1:
  - sum = acc + prod_data.
  - The accumulator is reset to 0 in the same cycle, so the next pixel starts with no bubble.
  - The result is formed from sum as follows.
- Result path:
  - Arithmetic shift sum right by FRAC.
  - Saturate to [−32768, 32767].
  - If RELU is 1, force negative values to 0.
- The write registers out_addr, out_din and the one-hot out_wea capture (r, c, m) of the pixel being completed, not the post-increment values.
- No write occurs while a pixel is still accumulating.
- Products presented while prod_ready = 0 are dropped, not accepted.
- A start pulse outside IDLE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - All counters and the accumulator are 0.
  - out_ena = 0, out_wea = 8'h00, out_addr = 0, out_din = 0.
  - prod_ready = 0, busy = 0, done = 0.
- prod_ready and busy rise the cycle after start.
- Write latency is 1 cycle: the pixel's last product is accepted at edge t, and out_ena/out_wea/out_addr/out_din are valid for exactly the cycle after edge t.
- Outside write cycles, out_ena = 0 and out_wea = 0. out_addr and out_din hold their values.
- Back-to-back pixels are supported: writes can occur on consecutive cycles when K·K·IN_CH = 1.
- Sequence at the end of a layer:
  - The final write cycle is also the first cycle of DONE, with prod_ready = 0.
  - done pulses in that same cycle.
  - The state returns to IDLE on the next edge.
- Asserting reset_n low mid-layer immediately forces the reset values. A partially accumulated pixel is discarded and no write is issued.

## Structure
- A shared conv package holds:
  - the default layer constants K, IN_CH, OUT_SIZE, OUT_CH;
  - the address width (16) and data width (16);
  - the state enum {IDLE, RUN, DONE}.
- One natural sub-module is sat_shift: the combinational shift, saturate and ReLU stage. Parameters are FRAC and RELU; the input is 32-bit signed and the output is 16-bit signed.
- Counters, the FSM and the write registers live in ofm_writer.

## Test plan
- Reset then idle, no start → all outputs 0, no out_ena for 100 cycles.
- Basic accumulation:
  - Setup: K=1, IN_CH=1, OUT_SIZE=2, OUT_CH=1, FRAC=0; start, then products 1, 2, 3, 4 on consecutive cycles.
  - Required: four writes on consecutive cycles with addr 0..3, din 1..4, out_wea 8'h01, then done.
- Default parameters, all products = 16'h0100, FRAC=8:
  - Each pixel sums 25·256 = 6400 and shifts to 25.
  - Required: 28·28·6 writes total; the first channel-1 write has addr 0 and out_wea 8'h02; the last write has addr 783 and out_wea 8'h20.
- Saturation and ReLU:
  - K=5, FRAC=0, products of +32767 → din 32767.
  - Products of −32768 → din 0 with RELU=1 and din −32768 with RELU=0.
- Flow control:
  - Drive prod_valid in a random 30% pattern.
  - Required: write count and values identical to the gap-free run; no write before the 25th accepted product.
- Mid-operation events:
  - reset_n low after 10 products of pixel 3 → outputs return to 0 immediately; the restarted layer produces correct values from address 0.
  - start pulsed during RUN → ignored.

Source files
------------

// File: rtl/ofm_writer_pkg.sv
// Shared layer constants, widths and controller state encoding for the
// output feature-map write-back path.
package ofm_writer_pkg;

  localparam int K_DEF        = 5;
  localparam int IN_CH_DEF    = 1;
  localparam int OUT_SIZE_DEF = 28;
  localparam int OUT_CH_DEF   = 6;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ofm_writer_sat_shift.sv
// Result stage: arithmetic right shift of the accumulator, saturation to
// 16-bit signed and optional ReLU clamp. Purely combinational.
module sat_shift
  import ofm_writer_pkg::*;
#(
  parameter int FRAC = 8,
  parameter int RELU = 1
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic signed [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> FRAC;
    if (shifted > 32'sd32767) begin
      result = 16'sh7fff;
    end else if (shifted < -32'sd32768) begin
      result = 16'sh8000;
    end else begin
      result = shifted[DATA_W-1:0];
    end
    if ((RELU != 0) && result[DATA_W-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/ofm_writer.sv
// Output write-back controller: accumulates K*K*IN_CH products per pixel and
// writes the scaled result to the output buffer in m/r/c order.
//
// state | meaning
// IDLE  | waiting for start, prod_ready low
// RUN   | accepting products, writing one result per completed pixel
// DONE  | final write cycle, done pulses, returns to IDLE
module ofm_writer
  import ofm_writer_pkg::*;
#(
  parameter int K        = K_DEF,
  parameter int IN_CH    = IN_CH_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int OUT_CH   = OUT_CH_DEF,
  parameter int FRAC     = 8,
  parameter int RELU     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              prod_valid,
  input  logic [DATA_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              out_ena,
  output logic [7:0]        out_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_din,
  output logic              busy,
  output logic              done
);

  localparam int PIX_N = K * K * IN_CH;
  localparam int CNT_W = $clog2(PIX_N + 1);
  localparam int POS_W = $clog2(OUT_SIZE + 1);

  state_t                   state;
  logic [CNT_W-1:0]         acc_cnt;
  logic [POS_W-1:0]         c;
  logic [POS_W-1:0]         r;
  logic [2:0]               m;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DATA_W-1:0] result;
  logic [ADDR_W-1:0]        pix_addr;
  logic                     accept;
  logic                     pix_last;
  logic                     c_last;
  logic                     r_last;
  logic                     m_last;

  assign accept   = prod_valid && prod_ready;
  assign sum      = acc + {{(ACC_W-DATA_W){prod_data[DATA_W-1]}}, prod_data};
  assign pix_last = (acc_cnt == CNT_W'(PIX_N - 1));
  assign c_last   = (c == POS_W'(OUT_SIZE - 1));
  assign r_last   = (r == POS_W'(OUT_SIZE - 1));
  assign m_last   = (m == 3'(OUT_CH - 1));
  assign pix_addr = ADDR_W'(r) * ADDR_W'(OUT_SIZE) + ADDR_W'(c);

  sat_shift #(
    .FRAC (FRAC),
    .RELU (RELU)
  ) u_sat_shift (
    .sum    (sum),
    .result (result)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      c          <= '0;
      r          <= '0;
      m          <= '0;
      acc        <= '0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_ena    <= 1'b0;
      out_wea    <= '0;
      out_addr   <= '0;
      out_din    <= '0;
    end else begin
      out_ena <= 1'b0;
      out_wea <= '0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            prod_ready <= 1'b1;
            busy       <= 1'b1;
            acc_cnt    <= '0;
            c          <= '0;
            r          <= '0;
            m          <= '0;
            acc        <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (!pix_last) begin
              acc     <= sum;
              acc_cnt <= acc_cnt + CNT_W'(1);
            end else begin
              // Write captures the pixel being completed, before the counters advance
              acc      <= '0;
              acc_cnt  <= '0;
              out_ena  <= 1'b1;
              out_wea  <= 8'd1 << m;
              out_addr <= pix_addr;
              out_din  <= result;
              if (!c_last) begin
                c <= c + POS_W'(1);
              end else begin
                c <= '0;
                if (!r_last) begin
                  r <= r + POS_W'(1);
                end else begin
                  r <= '0;
                  if (!m_last) begin
                    m <= m + 3'd1;
                  end else begin
                    m          <= '0;
                    state      <= DONE;
                    prod_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                  end
                end
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
